fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the in-order integer pipeline. It tracks its own copy of the destination and source tags of every in-flight instruction from EX through the last forwarding-capable stage. It produces per-operand forward selects for the instruction in EX, with the youngest producer winning. It also raises a one-cycle load-use stall for the instruction in ID. It sits beside the ID/EX register and drives the EX operand muxes and the PC/IF-ID hold enables.

---
 rtl/fwd_hazard_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use stall logic for the in-order
// integer pipeline. It keeps a private tag pipeline (EX plus DEPTH stages
// after it) and derives the per-operand forward selects for EX and the
// load-use stall for ID from that copy.
// Optional build macro: HAZ_STATS_EN adds saturating 16-bit stall and forward
// counters; without it stall_cnt and fwd_cnt are tied to zero.
module fwd_hazard_unit #(
    parameter int RA_W  = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]        id_rd,
    input  logic                   id_regwr,
    input  logic                   id_load,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SEL_W-1:0]  fwd_sel,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            fwd_cnt
);

    // Tag pipeline, index 0 = EX, index k = k-th register after EX.
    logic [DEPTH:0]        vld_q, vld_d;
    logic [DEPTH:0]        regwr_q, regwr_d;
    logic [DEPTH:0]        load_q, load_d;
    logic [RA_W-1:0]       rd_q [DEPTH+1];
    logic [RA_W-1:0]       rd_d [DEPTH+1];
    logic [NSRC*RA_W-1:0]  rs_q, rs_d;

    // Next-state: stage 0 captures ID unless flushed or stalled, the rest shift.
    always_comb begin
        vld_d   = '0;
        regwr_d = '0;
        load_d  = '0;
        rd_d    = '{default: '0};
        rs_d    = id_rs;

        vld_d[0]   = id_valid && !flush && !stall;
        regwr_d[0] = id_regwr;
        load_d[0]  = id_load;
        rd_d[0]    = id_rd;

        for (int k = 1; k <= DEPTH; k++) begin
            vld_d[k]   = vld_q[k-1];
            regwr_d[k] = regwr_q[k-1];
            load_d[k]  = load_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    // Valid bits are the only tag state that needs clearing on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Tag payload; meaningless whenever the matching valid bit is low.
    always_ff @(posedge clk) begin
        regwr_q <= regwr_d;
        load_q  <= load_d;
        rd_q    <= rd_d;
        rs_q    <= rs_d;
    end

    // Forward select per EX operand: scan oldest to youngest so the youngest
    // matching producer overwrites and wins. A load in stage 1 has no data yet;
    // the stall keeps that case from ever arising, so it is simply excluded.
    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (vld_q[0] && vld_q[k] && regwr_q[k] &&
                    (rd_q[k] != '0) &&
                    (rd_q[k] == rs_q[s*RA_W +: RA_W]) &&
                    ((k >= 2) || !load_q[k])) begin
                    fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    // Load-use stall: a load in EX writing a register that the ID instruction reads.
    always_comb begin
        stall = 1'b0;
        if (id_valid && vld_q[0] && load_q[0] && regwr_q[0] && (rd_q[0] != '0)) begin
            for (int s = 0; s < NSRC; s++) begin
                if (id_rs[s*RA_W +: RA_W] == rd_q[0]) begin
                    stall = 1'b1;
                end
            end
        end
    end

`ifdef HAZ_STATS_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] fwd_num;

    // Counter next-state: add this cycle's stall and number of forwarded operands.
    always_comb begin
        fwd_num = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (fwd_sel[s*SEL_W +: SEL_W] != '0) begin
                fwd_num = fwd_num + 16'd1;
            end
        end
        stall_cnt_d = sat_add16(stall_cnt_q, {15'd0, stall});
        fwd_cnt_d   = sat_add16(fwd_cnt_q, fwd_num);
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
